drv_step_decoder: RTL and testbench

//  Receive end of the stepper-driver step/dir interface driven by TR_pulse. Synchronises drv_step and
//  drv_dir, counts steps into a signed position, and measures the step period in clk cycles (same
//  17-bit scale as N). Detects stall (timeout), over-speed and steps-while-disabled.

---
 rtl/drv_pkg.sv | 13 +
 rtl/sync_edge.sv | 30 +++
 rtl/drv_step_decoder.sv | 140 ++++++++++++++
 tb/tb_drv_step_decoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drv_pkg.sv
// Shared definitions for the step/dir receive path.
package drv_pkg;

    localparam int unsigned PERIOD_W = 17;

    localparam logic DIR_POS = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a rising-edge strobe on the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~prev;

endmodule

// File: rtl/drv_step_decoder.sv
// Step/dir receiver: position counter, step-period measurement and fault flags.
module drv_step_decoder
    import drv_pkg::*;
#(
    parameter int unsigned POS_W      = 32,
    parameter int unsigned PERIOD_W   = drv_pkg::PERIOD_W,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned MIN_PERIOD = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       drv_step,
    input  logic                       drv_dir,
    input  logic                       drv_enable_SM,
    input  logic                       pos_clear,
    input  logic                       err_clear,
    output logic signed [POS_W-1:0]    pos,
    output logic        [PERIOD_W-1:0] period,
    output logic                       period_valid,
    output logic                       moving,
    output logic                       dir_last,
    output logic                       err_fast,
    output logic                       err_dis_step
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] MIN_C     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);

    state_t              state;
    state_t              state_next;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_next;
    logic                period_load;
    logic                fast_hit;

    logic step_rise;
    logic step_level_unused;
    logic dir_sync;
    logic dir_rise_unused;
    logic accepted;

    sync_edge u_step_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (drv_step),
        .dout (step_level_unused),
        .rise (step_rise)
    );

    sync_edge u_dir_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (drv_dir),
        .dout (dir_sync),
        .rise (dir_rise_unused)
    );

    assign accepted = step_rise & drv_enable_SM;
    assign moving   = (state == RUN);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, period counter and measurement decisions; a step beats a coincident timeout
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        period_load = 1'b0;
        fast_hit    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (accepted) begin
                    state_next = RUN;
                    cnt_next   = CNT_ONE;
                end
            end
            RUN: begin
                if (accepted) begin
                    period_load = 1'b1;
                    fast_hit    = (cnt < MIN_C);
                    cnt_next    = CNT_ONE;
                end else if (cnt >= TIMEOUT_C) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Period counter, captured period and its one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            period_valid <= period_load;
            if (period_load) period <= cnt;
        end
    end

    // Position and direction of last accepted step; clear drops a coincident step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= '0;
            dir_last <= 1'b0;
        end else begin
            if (pos_clear)
                pos <= '0;
            else if (accepted)
                pos <= (dir_sync == DIR_POS) ? pos + POS_W'(1) : pos - POS_W'(1);
            if (accepted) dir_last <= dir_sync;
        end
    end

    // Sticky fault flags; a new fault wins over a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_fast     <= 1'b0;
            err_dis_step <= 1'b0;
        end else begin
            err_fast     <= (err_fast & ~err_clear) | fast_hit;
            err_dis_step <= (err_dis_step & ~err_clear) | (step_rise & ~drv_enable_SM);
        end
    end

endmodule

// File: tb/tb_drv_step_decoder.sv
// Randomised and directed bench for drv_step_decoder against a timestamp-based model.
module tb_drv_step_decoder;

    localparam int unsigned POS_W    = 8;
    localparam int unsigned PER_W    = 17;
    localparam int          TIMEOUT  = 2000;
    localparam int          MIN_PER  = 10;
    localparam longint      PER_MAX  = 131071;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_step = 1'b0;
    logic drv_dir = 1'b0;
    logic drv_enable_SM = 1'b0;
    logic pos_clear = 1'b0;
    logic err_clear = 1'b0;
    logic signed [POS_W-1:0] pos;
    logic [PER_W-1:0] period;
    logic period_valid;
    logic moving;
    logic dir_last;
    logic err_fast;
    logic err_dis_step;

    drv_step_decoder #(
        .POS_W      (POS_W),
        .PERIOD_W   (PER_W),
        .TIMEOUT    (TIMEOUT),
        .MIN_PERIOD (MIN_PER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .drv_step      (drv_step),
        .drv_dir       (drv_dir),
        .drv_enable_SM (drv_enable_SM),
        .pos_clear     (pos_clear),
        .err_clear     (err_clear),
        .pos           (pos),
        .period        (period),
        .period_valid  (period_valid),
        .moving        (moving),
        .dir_last      (dir_last),
        .err_fast      (err_fast),
        .err_dis_step  (err_dis_step)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pvcnt  = 0;
    bit done   = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every raw rising sample of drv_step becomes an event applied two clocks later;
    // period is the distance in clocks between accepted-step timestamps.
    typedef struct {
        longint due;
        logic   dir;
    } ev_t;

    ev_t    q[$];
    longint cyc = 0;
    longint e0 = 0;
    bit     prev_step = 1'b0;
    logic signed [POS_W-1:0] m_pos = '0;
    longint m_period = 0;
    bit     m_pv = 1'b0;
    bit     m_moving = 1'b0;
    bit     m_dir_last = 1'b0;
    bit     m_err_fast = 1'b0;
    bit     m_err_dis = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit     ev;
        bit     evdir;
        bit     acc;
        longint el;
        if (rst) begin
            q.delete();
            prev_step  = 1'b0;
            m_pos      = '0;
            m_period   = 0;
            m_pv       = 1'b0;
            m_moving   = 1'b0;
            m_dir_last = 1'b0;
            m_err_fast = 1'b0;
            m_err_dis  = 1'b0;
        end else begin
            cyc++;
            ev    = 1'b0;
            evdir = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                ev    = 1'b1;
                evdir = q[0].dir;
                void'(q.pop_front());
            end
            acc  = ev && drv_enable_SM;
            m_pv = 1'b0;
            if (err_clear) begin
                m_err_fast = 1'b0;
                m_err_dis  = 1'b0;
            end
            if (ev && !drv_enable_SM) m_err_dis = 1'b1;
            if (acc) begin
                if (m_moving) begin
                    el       = cyc - e0;
                    m_period = (el > PER_MAX) ? PER_MAX : el;
                    m_pv     = 1'b1;
                    if (el < MIN_PER) m_err_fast = 1'b1;
                end
                m_moving   = 1'b1;
                e0         = cyc;
                m_dir_last = evdir;
                if (!pos_clear) m_pos = evdir ? m_pos + 8'sd1 : m_pos - 8'sd1;
            end else if (m_moving && (cyc - e0) >= TIMEOUT) begin
                m_moving = 1'b0;
            end
            if (pos_clear) m_pos = '0;
            if (drv_step && !prev_step) q.push_back('{cyc + 2, drv_dir});
            prev_step = drv_step;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!done) begin
            chk("pos",          longint'(pos),          longint'(m_pos));
            chk("period",       longint'(period),       m_period);
            chk("period_valid", longint'(period_valid), longint'(m_pv));
            chk("moving",       longint'(moving),       longint'(m_moving));
            chk("dir_last",     longint'(dir_last),     longint'(m_dir_last));
            chk("err_fast",     longint'(err_fast),     longint'(m_err_fast));
            chk("err_dis_step", longint'(err_dis_step), longint'(m_err_dis));
            if (period_valid) pvcnt++;
        end
    end

    task automatic pulse(input int hi, input int lo);
        @(negedge clk) drv_step = 1'b1;
        repeat (hi) @(negedge clk);
        drv_step = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    initial begin
        int p0;
        int pv0;
        int m0;
        int n;
        int hi;
        int lo;

        repeat (4) @(negedge clk);
        chk("reset_pos", longint'(pos), 0);
        chk("reset_moving", longint'(moving), 0);
        @(negedge clk) rst = 1'b0;

        // 1: ten forward steps every 100 clk
        drv_dir = 1'b1;
        drv_enable_SM = 1'b1;
        pv0 = pvcnt;
        for (int i = 0; i < 10; i++) pulse(50, 50);
        chk("t1_pos", longint'(pos), 10);
        chk("t1_strobes", pvcnt - pv0, 9);
        chk("t1_period", longint'(period), 100);
        chk("t1_moving", longint'(moving), 1);

        // 2: five reverse steps every 250 clk, then stall
        @(negedge clk) drv_dir = 1'b0;
        for (int i = 0; i < 5; i++) pulse(125, 125);
        chk("t2_pos", longint'(pos), 5);
        chk("t2_period", longint'(period), 250);
        chk("t2_dir_last", longint'(dir_last), 0);
        repeat (TIMEOUT + 50) @(negedge clk);
        chk("t2_stalled", longint'(moving), 0);
        pv0 = pvcnt;
        pulse(50, 50);
        chk("t2_restart_no_strobe", pvcnt - pv0, 0);
        chk("t2_restart_moving", longint'(moving), 1);

        // Step landing exactly on the timeout cycle is measured; one cycle later is not
        pulse(50, TIMEOUT - 50);
        pv0 = pvcnt;
        pulse(50, 50);
        chk("t2_edge_timeout_period", longint'(period), TIMEOUT);
        chk("t2_edge_timeout_strobe", pvcnt - pv0, 1);
        pulse(50, TIMEOUT - 49);
        pv0 = pvcnt;
        pulse(50, 50);
        chk("t2_past_timeout_strobe", pvcnt - pv0, 0);

        // 3: wrap at the top of an 8-bit position, then clear racing a step
        @(negedge clk) drv_dir = 1'b1;
        n = 127 - int'(m_pos);
        for (int i = 0; i < n; i++) pulse(2, 2);
        chk("t3_preload", longint'(pos), 127);
        pulse(2, 2);
        chk("t3_wrap", longint'(pos), -128);
        pv0 = pvcnt;
        @(negedge clk) pos_clear = 1'b1;
        pulse(2, 2);
        pos_clear = 1'b0;
        chk("t3_clear_wins", longint'(pos), 0);
        chk("t3_clear_still_measures", pvcnt - pv0, 1);

        // 4: fast steps set err_fast; clear works; clear racing a new fault loses
        pulse(20, 20);
        @(negedge clk) err_clear = 1'b1;
        @(negedge clk) err_clear = 1'b0;
        chk("t4_cleared", longint'(err_fast), 0);
        p0 = int'(pos);
        pulse(3, 3);
        pulse(3, 30);
        chk("t4_err_fast", longint'(err_fast), 1);
        chk("t4_pos_plus2", longint'(pos) - p0, 2);
        @(negedge clk) err_clear = 1'b1;
        @(negedge clk) err_clear = 1'b0;
        chk("t4_cleared2", longint'(err_fast), 0);
        pulse(20, 20);
        pulse(3, 3);
        @(negedge clk) drv_step = 1'b1;
        @(negedge clk);
        @(negedge clk) err_clear = 1'b1;
        @(negedge clk) begin
            err_clear = 1'b0;
            drv_step = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("t4_set_beats_clear", longint'(err_fast), 1);

        // 5: steps while disabled
        @(negedge clk) drv_enable_SM = 1'b0;
        p0 = int'(pos);
        m0 = int'(moving);
        for (int i = 0; i < 3; i++) pulse(20, 20);
        chk("t5_pos_held", longint'(pos), p0);
        chk("t5_err_dis", longint'(err_dis_step), 1);
        chk("t5_moving_held", longint'(moving), m0);
        @(negedge clk) drv_enable_SM = 1'b1;

        // 6: asynchronous reset in the middle of a train
        for (int i = 0; i < 4; i++) pulse(25, 25);
        @(negedge clk) drv_step = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_pos", longint'(pos), 0);
        chk("t6_async_moving", longint'(moving), 0);
        chk("t6_async_err", longint'(err_fast) + longint'(err_dis_step), 0);
        drv_step = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pv0 = pvcnt;
        pulse(25, 25);
        chk("t6_first_pos", longint'(pos), 1);
        chk("t6_first_no_strobe", pvcnt - pv0, 0);
        pulse(25, 25);
        chk("t6_second_period", longint'(period), 50);

        // Randomised traffic
        for (int i = 0; i < 250; i++) begin
            hi = int'($urandom_range(2, 6));
            lo = int'($urandom_range(2, 40));
            if ($urandom_range(0, 39) == 0) lo = TIMEOUT - hi + int'($urandom_range(0, 4)) - 2;
            @(negedge clk) begin
                drv_dir = 1'($urandom_range(0, 1));
                drv_enable_SM = ($urandom_range(0, 9) != 0);
                drv_step = 1'b1;
            end
            repeat (hi) @(negedge clk);
            drv_step = 1'b0;
            for (int k = 0; k < lo - 1; k++) begin
                pos_clear = ($urandom_range(0, 49) == 0);
                err_clear = ($urandom_range(0, 49) == 0);
                @(negedge clk);
            end
            pos_clear = 1'b0;
            err_clear = 1'b0;
        end
        repeat (5) @(negedge clk);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
